// File: rtl/rx_frame_reader_pkg.sv
// rx_frame_reader_pkg: shared buffer geometry, frame layout constants and FSM states
// for the rx audio sample-buffer reader.
package rx_frame_reader_pkg;

    localparam int RXBUF_SIZE     = 8192;
    localparam int ADDR_W_DEF     = $clog2(RXBUF_SIZE);
    localparam int WORDS_PER_SAMP = 3;
    localparam int TICKS_WORDS    = 3;
    localparam int CTR_WORDS      = 1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RD_I,
        ST_RD_Q,
        ST_RD_X,
        ST_PRESENT,
        ST_RD_T0,
        ST_RD_T1,
        ST_RD_T2,
        ST_RD_CTR,
        ST_DONE
    } state_e;

    function automatic logic [17:0] frame_len(input logic [15:0] n);
        return 18'(WORDS_PER_SAMP) * {2'b00, n} + 18'(TICKS_WORDS + CTR_WORDS);
    endfunction

endpackage

// File: rtl/rx_frame_reader_word_fetch.sv
// rx_buf_word_fetch: two-cycle issue/capture read unit; owns the read pointer and
// presents each returned buffer word with a one-cycle word_valid_o.
module rx_buf_word_fetch
    import rx_frame_reader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              adc_clk,
    input  logic              reset,
    input  logic              req_i,
    input  logic [15:0]       mem_dout_i,
    output logic              mem_rd_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [ADDR_W-1:0] rd_ptr_o,
    output logic              word_valid_o,
    output logic [15:0]       word_o
);

    logic              pend_q;
    logic [ADDR_W-1:0] rd_ptr_q;

    // A request held across the capture cycle does not re-issue until the word lands.
    assign mem_rd_o     = req_i && !pend_q;
    assign mem_addr_o   = rd_ptr_q;
    assign rd_ptr_o     = rd_ptr_q;
    assign word_valid_o = pend_q;
    assign word_o       = mem_dout_i;

    always_ff @(posedge adc_clk) begin
        if (reset) begin
            pend_q   <= 1'b0;
            rd_ptr_q <= '0;
        end else begin
            pend_q <= mem_rd_o;
            if (mem_rd_o) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

endmodule

// File: rtl/rx_frame_reader.sv
// rx_frame_reader: reads I/Q/X triplets, 48-bit ticks and the buffer counter out of the
// shared rx sample buffer, streams samples and reports per-frame ticks/counter/errors.
module rx_frame_reader
    import rx_frame_reader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              adc_clk,
    input  logic              reset,
    input  logic [15:0]       nrx_samps,
    input  logic [ADDR_W-1:0] wr_ptr,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [15:0]       mem_dout,
    output logic [ADDR_W-1:0] rd_ptr,
    output logic              samp_valid,
    input  logic              samp_ready,
    output logic [15:0]       samp_i,
    output logic [15:0]       samp_q,
    output logic [15:0]       samp_x,
    output logic [15:0]       samp_idx,
    output logic              frame_done,
    output logic [47:0]       frame_ticks,
    output logic [15:0]       frame_ctr,
    output logic              seq_err,
    output logic              overrun,
    output logic              cfg_err,
    input  logic              clr_err
);

    localparam int DEPTH = 1 << ADDR_W;

    state_e      state_q;
    logic [15:0] nsamp_q, samp_i_q, samp_q_q, samp_x_q, samp_idx_q, frame_ctr_q;
    logic [47:0] ticks_sh_q, frame_ticks_q;
    logic        samp_valid_q, frame_done_q, seen_q, seq_err_q, overrun_q, cfg_err_q;
    logic        req, word_valid;
    logic [15:0] word;
    logic [18:0] flen_w, level_w, depth_w;

    assign req     = state_q inside {ST_RD_I, ST_RD_Q, ST_RD_X, ST_RD_T0, ST_RD_T1, ST_RD_T2, ST_RD_CTR};
    assign flen_w  = {1'b0, frame_len(nrx_samps)};
    assign level_w = 19'(ADDR_W'(wr_ptr - rd_ptr));
    assign depth_w = 19'(DEPTH);

    rx_buf_word_fetch #(.ADDR_W(ADDR_W)) u_fetch (
        .adc_clk      (adc_clk),
        .reset        (reset),
        .req_i        (req),
        .mem_dout_i   (mem_dout),
        .mem_rd_o     (mem_rd),
        .mem_addr_o   (mem_addr),
        .rd_ptr_o     (rd_ptr),
        .word_valid_o (word_valid),
        .word_o       (word)
    );

    always_ff @(posedge adc_clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            nsamp_q       <= '0;
            samp_i_q      <= '0;
            samp_q_q      <= '0;
            samp_x_q      <= '0;
            samp_idx_q    <= '0;
            samp_valid_q  <= 1'b0;
            frame_done_q  <= 1'b0;
            ticks_sh_q    <= '0;
            frame_ticks_q <= '0;
            frame_ctr_q   <= '0;
            seen_q        <= 1'b0;
            seq_err_q     <= 1'b0;
            overrun_q     <= 1'b0;
            cfg_err_q     <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            // Clear first so any flag set later in this cycle takes priority.
            if (clr_err) begin
                seq_err_q <= 1'b0;
                overrun_q <= 1'b0;
                cfg_err_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    nsamp_q    <= nrx_samps;
                    samp_idx_q <= '0;
                    if (flen_w > depth_w) cfg_err_q <= 1'b1;
                    else if (level_w >= flen_w) begin
                        state_q <= (nrx_samps == 16'd0) ? ST_RD_T0 : ST_RD_I;
                        if (level_w > depth_w - flen_w) overrun_q <= 1'b1;
                    end
                end
                ST_RD_I: if (word_valid) begin
                    samp_i_q <= word;
                    state_q  <= ST_RD_Q;
                end
                ST_RD_Q: if (word_valid) begin
                    samp_q_q <= word;
                    state_q  <= ST_RD_X;
                end
                ST_RD_X: if (word_valid) begin
                    samp_x_q     <= word;
                    samp_valid_q <= 1'b1;
                    state_q      <= ST_PRESENT;
                end
                ST_PRESENT: if (samp_ready) begin
                    samp_valid_q <= 1'b0;
                    if (samp_idx_q + 16'd1 == nsamp_q) state_q <= ST_RD_T0;
                    else begin
                        samp_idx_q <= samp_idx_q + 16'd1;
                        state_q    <= ST_RD_I;
                    end
                end
                ST_RD_T0: if (word_valid) begin
                    ticks_sh_q[15:0] <= word;
                    state_q          <= ST_RD_T1;
                end
                ST_RD_T1: if (word_valid) begin
                    ticks_sh_q[31:16] <= word;
                    state_q           <= ST_RD_T2;
                end
                ST_RD_T2: if (word_valid) begin
                    ticks_sh_q[47:32] <= word;
                    state_q           <= ST_RD_CTR;
                end
                ST_RD_CTR: if (word_valid) begin
                    frame_ctr_q   <= word;
                    frame_ticks_q <= ticks_sh_q;
                    frame_done_q  <= 1'b1;
                    seen_q        <= 1'b1;
                    if (seen_q && word != frame_ctr_q + 16'd1) seq_err_q <= 1'b1;
                    state_q       <= ST_DONE;
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign samp_valid  = samp_valid_q;
    assign samp_i      = samp_i_q;
    assign samp_q      = samp_q_q;
    assign samp_x      = samp_x_q;
    assign samp_idx    = samp_idx_q;
    assign frame_done  = frame_done_q;
    assign frame_ticks = frame_ticks_q;
    assign frame_ctr   = frame_ctr_q;
    assign seq_err     = seq_err_q;
    assign overrun     = overrun_q;
    assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_rx_frame_reader.sv
// tb_rx_frame_reader: directed bench for rx_frame_reader with a 1-cycle-latency buffer model.
module tb_rx_frame_reader;

    localparam int AW    = 13;
    localparam int DEPTH = 8192;

    logic          adc_clk = 1'b0;
    logic          reset = 1'b1;
    logic          samp_ready = 1'b1;
    logic          clr_err = 1'b0;
    logic [15:0]   nrx_samps = 16'd0;
    logic [15:0]   mem_dout = 16'd0;
    logic [AW-1:0] wr_ptr = '0;
    logic          mem_rd, samp_valid, frame_done, seq_err, overrun, cfg_err;
    logic [AW-1:0] mem_addr, rd_ptr;
    logic [15:0]   samp_i, samp_q, samp_x, samp_idx, frame_ctr;
    logic [47:0]   frame_ticks;

    logic [15:0] mem [DEPTH];
    int          checks = 0, errors = 0;
    int          cyc = 0, rd_cnt = 0, sv_cnt = 0, hs_n = 0, fd_n = 0, fd_cyc = 0;
    logic [63:0] hs_w [64];
    int          hs_c [64];
    int          b, t, s, r;

    rx_frame_reader #(.ADDR_W(AW)) dut (
        .adc_clk(adc_clk), .reset(reset), .nrx_samps(nrx_samps), .wr_ptr(wr_ptr),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_dout(mem_dout), .rd_ptr(rd_ptr),
        .samp_valid(samp_valid), .samp_ready(samp_ready), .samp_i(samp_i), .samp_q(samp_q),
        .samp_x(samp_x), .samp_idx(samp_idx), .frame_done(frame_done),
        .frame_ticks(frame_ticks), .frame_ctr(frame_ctr), .seq_err(seq_err),
        .overrun(overrun), .cfg_err(cfg_err), .clr_err(clr_err)
    );

    always #5 adc_clk = ~adc_clk;

    always @(posedge adc_clk) if (mem_rd) mem_dout <= mem[mem_addr];

    always @(posedge adc_clk) begin
        cyc++;
        if (mem_rd) rd_cnt++;
        if (samp_valid) sv_cnt++;
        if (samp_valid && samp_ready) begin
            hs_w[hs_n % 64] = {samp_idx, samp_i, samp_q, samp_x};
            hs_c[hs_n % 64] = cyc;
            hs_n++;
        end
        if (frame_done) begin
            fd_n++;
            fd_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input int base, input int n, input logic [15:0] s0,
                        input logic [47:0] tk, input logic [15:0] c);
        int a = base;
        for (int k = 0; k < 3 * n; k++) begin
            mem[a % DEPTH] = s0 + 16'(k);
            a++;
        end
        mem[a % DEPTH]       = tk[15:0];
        mem[(a + 1) % DEPTH] = tk[31:16];
        mem[(a + 2) % DEPTH] = tk[47:32];
        mem[(a + 3) % DEPTH] = c;
    endtask

    task automatic wait_fd(input int tgt, input int budget, input string tag);
        int k = 0;
        while (fd_n < tgt && k < budget) begin
            @(negedge adc_clk);
            k++;
        end
        chk(tag, 64'(fd_n >= tgt), 64'd1);
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(negedge adc_clk);
        clr_err = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < DEPTH; k++) mem[k] = 16'd0;
        nrx_samps = 16'd2;
        repeat (3) @(negedge adc_clk);
        chk("reset_outs", 64'({mem_rd, rd_ptr, samp_valid, frame_done, seq_err, overrun, cfg_err, samp_idx}), 64'd0);
        chk("reset_frame", 64'({frame_ticks, frame_ctr}), 64'd0);
        reset = 1'b0;
        @(negedge adc_clk);

        // basic two-sample frame
        load(0, 2, 16'h0101, 48'h0000_0001_0002, 16'd5);
        b = hs_n; t = fd_n + 1;
        wr_ptr = 13'd10;
        @(negedge adc_clk);
        chk("t1_issue", 64'({mem_rd, mem_addr}), 64'({1'b1, 13'd0}));
        repeat (5) @(negedge adc_clk);
        chk("t1_valid_early", 64'(samp_valid), 64'd0);
        @(negedge adc_clk);
        chk("t1_valid_rise", 64'(samp_valid), 64'd1);
        chk("t1_trip0_out", {samp_idx, samp_i, samp_q, samp_x}, 64'h0000_0101_0102_0103);
        wait_fd(t, 100, "t1_done");
        chk("t1_hs0", hs_w[b % 64], 64'h0000_0101_0102_0103);
        chk("t1_hs1", hs_w[(b + 1) % 64], 64'h0001_0104_0105_0106);
        chk("t1_gap", 64'(hs_c[(b + 1) % 64] - hs_c[b % 64]), 64'd7);
        chk("t1_done_lat", 64'(fd_cyc - hs_c[(b + 1) % 64]), 64'd9);
        chk("t1_ticks", 64'(frame_ticks), 64'h0000_0001_0002);
        chk("t1_ctr", 64'(frame_ctr), 64'd5);
        chk("t1_flags", 64'({seq_err, overrun, cfg_err}), 64'd0);
        chk("t1_rdptr", 64'(rd_ptr), 64'd10);

        // counter sequence checking
        nrx_samps = 16'd1;
        load(10, 1, 16'h0111, 48'h0, 16'd7);
        t = fd_n + 1; wr_ptr = 13'd17;
        wait_fd(t, 100, "seq1_done");
        chk("seq_gap_err", 64'(seq_err), 64'd1);
        chk("seq_ctr7", 64'(frame_ctr), 64'd7);
        pulse_clr();
        chk("seq_clr", 64'(seq_err), 64'd0);
        load(17, 1, 16'h0121, 48'h0, 16'hFFFF);
        t = fd_n + 1; wr_ptr = 13'd24;
        wait_fd(t, 100, "seq2_done");
        pulse_clr();
        load(24, 1, 16'h0131, 48'h0, 16'h0000);
        t = fd_n + 1; wr_ptr = 13'd31;
        wait_fd(t, 100, "seq3_done");
        chk("seq_wrap_ok", 64'(seq_err), 64'd0);
        chk("seq_ctr0", 64'(frame_ctr), 64'd0);

        // backpressure stall during triplet 0
        load(31, 2, 16'h0107, 48'h0, 16'd1);
        nrx_samps = 16'd2; samp_ready = 1'b0;
        r = rd_cnt; b = hs_n; t = fd_n + 1;
        wr_ptr = 13'd41;
        s = 0;
        while (!samp_valid && s < 20) begin
            @(negedge adc_clk);
            s++;
        end
        chk("stall_valid_rise", 64'(samp_valid), 64'd1);
        repeat (20) @(negedge adc_clk);
        chk("stall_valid_held", 64'(samp_valid), 64'd1);
        chk("stall_outs", {samp_idx, samp_i, samp_q, samp_x}, 64'h0000_0107_0108_0109);
        chk("stall_no_rd", 64'(rd_cnt - r), 64'd3);
        samp_ready = 1'b1;
        wait_fd(t, 100, "stall_done");
        chk("stall_hs0", hs_w[b % 64], 64'h0000_0107_0108_0109);
        chk("stall_hs1", hs_w[(b + 1) % 64], 64'h0001_010A_010B_010C);
        chk("stall_rds", 64'(rd_cnt - r), 64'd10);
        chk("stall_ctr", 64'(frame_ctr), 64'd1);

        // advance the read pointer to DEPTH-3 with three long frames
        nrx_samps = 16'd904;
        for (int f = 0; f < 3; f++) begin
            load(41 + f * 2716, 904, 16'h0, 48'h0, 16'(2 + f));
            t = fd_n + 1;
            wr_ptr = 13'(41 + (f + 1) * 2716);
            wait_fd(t, 7000, "fill_done");
        end
        chk("fill_rdptr", 64'(rd_ptr), 64'd8189);
        chk("fill_seq", 64'(seq_err), 64'd0);

        // frame straddling the buffer wrap
        load(8189, 2, 16'h0201, 48'h1234_5678_9ABC, 16'd5);
        nrx_samps = 16'd2;
        b = hs_n; t = fd_n + 1;
        wr_ptr = 13'd7;
        wait_fd(t, 100, "wrap_done");
        chk("wrap_hs0", hs_w[b % 64], 64'h0000_0201_0202_0203);
        chk("wrap_hs1", hs_w[(b + 1) % 64], 64'h0001_0204_0205_0206);
        chk("wrap_ticks", 64'(frame_ticks), 64'h1234_5678_9ABC);
        chk("wrap_rdptr", 64'(rd_ptr), 64'd7);
        chk("wrap_flags", 64'({seq_err, overrun, cfg_err}), 64'd0);

        // zero-sample frame
        load(7, 0, 16'h0, 48'h000A_000B_000C, 16'd6);
        nrx_samps = 16'd0; s = sv_cnt;
        wr_ptr = 13'd11;
        repeat (8) @(negedge adc_clk);
        chk("n0_done_early", 64'(frame_done), 64'd0);
        @(negedge adc_clk);
        chk("n0_done", 64'(frame_done), 64'd1);
        chk("n0_ticks", 64'(frame_ticks), 64'h000A_000B_000C);
        chk("n0_ctr", 64'(frame_ctr), 64'd6);
        chk("n0_no_valid", 64'(sv_cnt - s), 64'd0);

        // oversize frame configuration
        @(negedge adc_clk);
        nrx_samps = 16'd3000; r = rd_cnt;
        repeat (4) @(negedge adc_clk);
        chk("cfg_err_set", 64'(cfg_err), 64'd1);
        chk("cfg_no_rd", 64'(rd_cnt - r), 64'd0);
        chk("cfg_rdptr", 64'(rd_ptr), 64'd11);
        pulse_clr();
        chk("cfg_set_wins", 64'(cfg_err), 64'd1);
        nrx_samps = 16'd1;
        pulse_clr();
        chk("cfg_cleared", 64'(cfg_err), 64'd0);

        // reset mid-frame in RD_Q
        load(11, 1, 16'h0301, 48'h0, 16'd7);
        wr_ptr = 13'd18;
        repeat (3) @(negedge adc_clk);
        chk("rst_in_rdq", 64'({mem_rd, mem_addr}), 64'({1'b1, 13'd12}));
        chk("rst_pre_i", 64'(samp_i), 64'h0301);
        reset = 1'b1; wr_ptr = 13'd0; t = fd_n;
        @(negedge adc_clk);
        chk("rst_outs", {rd_ptr, mem_rd, samp_valid, frame_done, samp_i, samp_idx, frame_ctr}, 64'd0);
        chk("rst_ticks", 64'(frame_ticks), 64'd0);
        reset = 1'b0;
        repeat (15) @(negedge adc_clk);
        chk("rst_no_done", 64'(fd_n), 64'(t));

        // writer about to lap the reader; first frame after reset is not sequence-checked
        load(0, 1, 16'h0401, 48'h77, 16'h0040);
        b = hs_n; t = fd_n + 1;
        wr_ptr = 13'd8191;
        @(negedge adc_clk);
        chk("ovr_set", 64'(overrun), 64'd1);
        wait_fd(t, 100, "ovr_done");
        chk("ovr_hs0", hs_w[b % 64], 64'h0000_0401_0402_0403);
        chk("ovr_ctr", 64'(frame_ctr), 64'h0040);
        chk("ovr_ticks", 64'(frame_ticks), 64'h77);
        chk("ovr_no_seq", 64'(seq_err), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
